// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared types and helpers for the serial test-sequence transmitter.
//   state_t  - transmitter FSM states (ST_PAR is only entered when the
//              SEQ_TX_PARITY_EN macro is defined).
//   clip_len - maps a requested length onto the effective frame length.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A length of 0, or one longer than the pattern register, means
    // "send the whole pattern".
    function automatic int unsigned clip_len(input int unsigned len_in,
                                             input int unsigned pat_w);
        if (len_in == 0 || len_in > pat_w) begin
            return pat_w;
        end
        return len_in;
    endfunction

endpackage

// File: rtl/seq_tx_if.sv
// seq_tx_if: frame request / serial output bundle of seq_tx.
//   start, pattern, len : controller -> transmitter (frame request)
//   seq, valid, busy, done : transmitter -> controller / sequence detector
// Handshake: a frame is accepted on a rising clock edge where start=1 and the
// transmitter is not busy; pattern/len are captured on that same edge. While
// busy=1 start is dropped, never queued. valid=1 marks every cycle in which
// seq carries a frame bit; done pulses for one cycle after the last bit, and
// a start in that cycle is accepted so frames can run back-to-back.
interface seq_tx_if #(
    parameter int PAT_W = 8
);
    localparam int LW = $clog2(PAT_W + 1);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LW-1:0]    len;
    logic             seq;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len,
        input  seq, valid, busy, done
    );

    modport slave (
        input  start, pattern, len,
        output seq, valid, busy, done
    );
endinterface

// File: rtl/seq_tx_tick.sv
// seq_tx_tick: bit-period counter for seq_tx.
//   clk     - rising-edge clock
//   clear   - synchronous active-high reset
//   restart - frame accepted; realign the period to the new frame
//   en      - a frame bit (data or parity) is on the line
//   tick    - high in the last cycle of each DIV-cycle bit period
// With DIV=1 the counter never leaves 0, so tick is constantly high.
module seq_tx_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear || restart || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/seq_tx.sv
// seq_tx: serial test-sequence transmitter. Latches pattern[len-1:0] on an
// accepted start and shifts it out MSB-first on seq, one bit per DIV cycles.
//   clk       - rising-edge clock
//   clear     - synchronous active-high reset
//   bus       - seq_tx_if slave: start/pattern/len in, seq/valid/busy/done out
//   dbg_state - current FSM state, for observation only
// Parameters: PAT_W (max pattern bits), DIV (cycles per bit), IDLE_LVL (level
// of seq outside frames).
// Build option: define SEQ_TX_PARITY_EN to append an even-parity bit after
// the data bits (frame becomes n+1 bits, done moves DIV cycles later).
// All outputs are registered; nothing combinational reaches the outputs.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int   PAT_W    = 8,
    parameter int   DIV      = 1,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic       clk,
    input  logic       clear,
    seq_tx_if.slave    bus,
    output state_t     dbg_state
);
    localparam int IW = $clog2(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    first_idx;
    int unsigned      n_eff;
    logic             accept;
    logic             run;
    logic             tick;
`ifdef SEQ_TX_PARITY_EN
    logic             par_acc;
`endif

    always_comb begin
        n_eff     = clip_len(32'(bus.len), PAT_W);
        first_idx = IW'(n_eff - 1);
    end

    // DONE counts as not busy, so a start there chains the next frame.
    assign accept    = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign run       = (state == ST_SHIFT) || (state == ST_PAR);
    assign dbg_state = state;

    seq_tx_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .clear   (clear),
        .restart (accept),
        .en      (run),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= ST_IDLE;
            pat       <= '0;
            idx       <= '0;
            bus.seq   <= IDLE_LVL;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_acc   <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state     <= ST_SHIFT;
                        pat       <= bus.pattern;
                        idx       <= first_idx;
                        bus.seq   <= bus.pattern[first_idx];
                        bus.valid <= 1'b1;
                        bus.busy  <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
                        par_acc   <= 1'b0;
`endif
                    end else begin
                        state     <= ST_IDLE;
                        bus.seq   <= IDLE_LVL;
                        bus.valid <= 1'b0;
                        bus.busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
`ifdef SEQ_TX_PARITY_EN
                        par_acc <= par_acc ^ pat[idx];
`endif
                        if (idx == '0) begin
`ifdef SEQ_TX_PARITY_EN
                            // Parity must include the bit leaving the line now.
                            state   <= ST_PAR;
                            bus.seq <= par_acc ^ pat[idx];
`else
                            state     <= ST_DONE;
                            bus.done  <= 1'b1;
                            bus.busy  <= 1'b0;
                            bus.valid <= 1'b0;
                            bus.seq   <= IDLE_LVL;
`endif
                        end else begin
                            idx     <= idx - IW'(1);
                            bus.seq <= pat[idx - IW'(1)];
                        end
                    end
                end
                ST_PAR: begin
                    if (tick) begin
                        state     <= ST_DONE;
                        bus.done  <= 1'b1;
                        bus.busy  <= 1'b0;
                        bus.valid <= 1'b0;
                        bus.seq   <= IDLE_LVL;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: directed bench for seq_tx. Two instances share the clock and
// clear: dut1 (DIV=1, IDLE_LVL=0) and dut3 (DIV=3, IDLE_LVL=1). Expected
// serial bits are pushed to exp_q when a frame is driven and popped as the
// DUT shifts them out. Works with or without SEQ_TX_PARITY_EN defined.
module tb_seq_tx;
    import seq_tx_pkg::*;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    seq_tx_if #(.PAT_W(8)) b1 ();
    seq_tx_if #(.PAT_W(8)) b3 ();
    state_t st1, st3;

    seq_tx #(.PAT_W(8), .DIV(1), .IDLE_LVL(1'b0)) dut1 (
        .clk(clk), .clear(clear), .bus(b1), .dbg_state(st1)
    );
    seq_tx #(.PAT_W(8), .DIV(3), .IDLE_LVL(1'b1)) dut3 (
        .clk(clk), .clear(clear), .bus(b3), .dbg_state(st3)
    );

    int tests  = 0;
    int failed = 0;
    logic [0:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares {seq, valid, busy, done} of the selected DUT.
    task automatic chk_out(input int d, input string tag,
                           input logic s, input logic v, input logic b, input logic dn);
        logic [3:0] o;
        if (d == 1) o = {b1.seq, b1.valid, b1.busy, b1.done};
        else        o = {b3.seq, b3.valid, b3.busy, b3.done};
        chk(tag, {28'd0, o}, {28'd0, s, v, b, dn});
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 1) b1.start = v;
        else        b3.start = v;
    endtask

    task automatic set_req(input int d, input logic [7:0] p, input logic [3:0] l);
        if (d == 1) begin b1.pattern = p; b1.len = l; end
        else        begin b3.pattern = p; b3.len = l; end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle with
    // start low. poke=1 pulses start during cycles 3..4 of the frame.
    task automatic send(input int d, input logic [7:0] p, input logic [3:0] l, input bit poke);
        int n;
        int cyc;
        logic idle;
        logic par;
        logic [0:0] e;
        idle = (d == 3);
        n    = (l == 0 || l > 8) ? 8 : int'(l);
        par  = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back(p[i]);
            par ^= p[i];
        end
`ifdef SEQ_TX_PARITY_EN
        exp_q.push_back(par);
        n = n + 1;
`endif
        set_req(d, p, l);
        set_start(d, 1'b1);
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                cyc = 1 + k * d + c;
                if (cyc == 1) begin
                    set_start(d, 1'b0);
                    // Request inputs change after acceptance; frame must not.
                    set_req(d, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
                end
                chk_out(d, $sformatf("bit d%0d p%02h c%0d", d, p, cyc), e, 1'b1, 1'b1, 1'b0);
                if (poke && cyc == 3) set_start(d, 1'b1);
                if (poke && cyc == 4) set_start(d, 1'b0);
            end
        end
        @(negedge clk);
        chk_out(d, $sformatf("done d%0d p%02h", d, p), idle, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle_check(input int d, input string tag);
        @(negedge clk);
        chk_out(d, tag, (d == 3), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        clear = 1'b1;
        b1.start = 1'b0; b1.pattern = '0; b1.len = '0;
        b3.start = 1'b0; b3.pattern = '0; b3.len = '0;
        @(negedge clk);
        @(negedge clk);
        chk_out(1, "reset dut1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out(3, "reset dut3", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset state1", {30'd0, st1}, {30'd0, ST_IDLE});
        chk("reset state3", {30'd0, st3}, {30'd0, ST_IDLE});
        clear = 1'b0;
        idle_check(1, "idle after reset");

        // Basic, short, clipped (0 and >8) and single-bit frames.
        send(1, 8'b1011_0010, 4'd8, 1'b0);  idle_check(1, "idle basic");
        send(1, 8'b1011_0011, 4'd8, 1'b0);  idle_check(1, "idle odd ones");
        send(1, 8'hA5, 4'd4, 1'b0);         idle_check(1, "idle len4");
        send(1, 8'hA5, 4'd0, 1'b0);         idle_check(1, "idle len0");
        send(1, 8'h3C, 4'd12, 1'b0);        idle_check(1, "idle len12");
        send(1, 8'h01, 4'd1, 1'b0);         idle_check(1, "idle len1");

        // Bit period of 3 cycles.
        send(3, 8'hF0, 4'd8, 1'b0);         idle_check(3, "idle div3");

        // start during a frame is dropped; start in done chains with no gap.
        send(1, 8'hC3, 4'd8, 1'b1);         idle_check(1, "idle after poke");
        send(1, 8'h5A, 4'd8, 1'b0);
        send(1, 8'h96, 4'd3, 1'b0);         idle_check(1, "idle after b2b");
        send(3, 8'h81, 4'd8, 1'b1);
        send(3, 8'h7E, 4'd2, 1'b0);         idle_check(3, "idle after b2b div3");

        // clear in cycle 4 of the A5 frame: frame abandoned, no done.
        set_req(1, 8'hA5, 4'd8);
        set_start(1, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) set_start(1, 1'b0);
            chk_out(1, $sformatf("clr frame c%0d", c), a5[8 - c], 1'b1, 1'b1, 1'b0);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_out(1, "after clear", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("state after clear", {30'd0, st1}, {30'd0, ST_IDLE});
        for (int c = 6; c <= 11; c++) idle_check(1, $sformatf("no done c%0d", c));

        // clear and start together: clear wins, start lost.
        set_req(1, 8'hFF, 4'd8);
        set_start(1, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        set_start(1, 1'b0);
        chk_out(1, "clear+start", 1'b0, 1'b0, 1'b0, 1'b0);
        idle_check(1, "clear+start next");

        // Random frames on both instances.
        for (int r = 0; r < 6; r++) begin
            int d;
            d = (r % 2 == 0) ? 1 : 3;
            send(d, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b0);
            idle_check(d, $sformatf("idle rand %0d", r));
        end

        chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_tx.md
# seq_tx

Serial test-sequence transmitter: latches a parallel bit pattern on a start request and shifts it out MSB-first on a single serial line, one bit per bit period. It is the driving end of the `seq` serial input used by the sequence-detector blocks, and it produces stimulus frames for them in-system and on the bench. A ready/start handshake with busy/done status lets a controller queue frames back-to-back.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `DIV`, 1: clock cycles per serial bit (≥1).
- `IDLE_LVL`, 1'b0: level driven on `seq` when no frame is active.
- `clk` in 1: single clock, all logic rising-edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: frame request, sampled only while `busy`=0.
- `pattern` in PAT_W: bits to send; the active bits are `pattern[len-1:0]`.
- `len` in $clog2(PAT_W+1): number of bits to send; 0 or >PAT_W means PAT_W.
- `seq` out 1: serial output bit.
- `valid` out 1: high while `seq` carries a frame bit.
- `busy` out 1: frame in progress; `start` is ignored.
- `done` out 1: one-cycle pulse after the final bit period.

## Operation
- States: IDLE, SHIFT, PAR (parity, only when compiled in), DONE.
- IDLE: `seq`=IDLE_LVL, `valid`=0, `busy`=0. On `start`=1, latch `pattern`, effective length `n`, and set bit index = n-1. Go to SHIFT.
- SHIFT: `seq`=latched `pattern[idx]`, `valid`=1, `busy`=1. Hold each bit for DIV cycles. At the end of a period, decrement `idx`. After idx 0, go to PAR if enabled; otherwise go to DONE.
- PAR: drive the even-parity bit of the n transmitted bits for DIV cycles with `valid`=1, then go to DONE.
- DONE: one cycle. `done`=1, `busy`=0, `valid`=0, `seq`=IDLE_LVL. A `start` in this cycle is accepted, so the next frame begins on the following cycle. Otherwise go to IDLE.
- Changes to `pattern`/`len` after acceptance have no effect on the current frame.
- `start` while `busy`=1 is dropped. It is not queued.
- `len`=1: single-bit frame; legal.

## Timing
- Reset values: `seq`=IDLE_LVL, `valid`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- `start` sampled at edge E. The first bit appears on `seq` and `busy`=1 from E+1.
- Frame length is n·DIV cycles (plus DIV for parity). `done` is high in cycle E+1+n·DIV (+DIV).
- Outputs are registered; there is no combinational path from inputs to outputs.
- `clear` mid-frame: at the next edge all outputs return to reset values. No `done` pulse is generated and the frame is abandoned.
- `clear` and `start` asserted together: `clear` wins and the start is lost.

## Configuration
- `SEQ_TX_PARITY_EN` defined: the PAR state exists. An even-parity bit follows the data bits; frame = n+1 bits; `done` is delayed by DIV cycles.
- Not defined: no PAR state. `done` follows the last data bit directly.

## Structure
- `seq_tx_pkg`: state enum (IDLE, SHIFT, PAR, DONE) and the length-clip helper function.
- Sub-module `seq_tx_tick`: a bit-period counter. It is cleared on frame start and emits a one-cycle `tick` every DIV cycles. With DIV=1, `tick` is constantly high. The FSM/shift logic lives in `seq_tx`.

## Test plan
- Basic frame: DIV=1, `pattern`=8'b1011_0010, `len`=8, start at cycle 0.
  - `seq`=1,0,1,1,0,0,1,0 on cycles 1–8 with `valid`=1.
  - `done` high at cycle 9 (parity off).
- Short length and clipping: `pattern`=8'hA5, `len`=4 sends 0,1,0,1. `len`=0 sends all 8 bits 1,0,1,0,0,1,0,1.
- Bit period: DIV=3, `pattern`=8'hF0, `len`=8. Each bit is held 3 cycles; `done` is at cycle 25.
- Handshake:
  - Pulse `start` at cycle 3 of a frame; it is ignored.
  - Assert `start` in the `done` cycle; the new frame's first bit appears on the next cycle with no idle gap.
- Reset mid-frame: `clear` at cycle 4 of the 8'hA5 frame. Next cycle `seq`=IDLE_LVL, `busy`=0, `valid`=0, and no `done` pulse.
- Parity (`SEQ_TX_PARITY_EN`): `pattern`=8'b1011_0010 (four ones). Parity bit 0 at cycle 9, `done` at cycle 10. `pattern`=8'b1011_0011 gives parity bit 1.
